// File: rtl/apo_inject_queue_if.sv
// apo_inject_queue_if
// Bundles everything that passes between the compute node, the injection
// queue and the router's in_free port.
//   master : compute node / router / observer side
//   slave  : the injection queue
// Signals:
//   req_valid, req_dest   node offers a destination node number
//   req_ready             queue can take a request (not full)
//   link_busy             valid flags of in_r1R, in_r2R, in_r1L, in_r2L
//   out_free              packet towards the router's in_free
//   err_dest              one-cycle pulse: out-of-range destination dropped
//   q_level               current FIFO occupancy
//   inj_count             packets injected (wrapping)
//   stall_count           READY cycles blocked by link traffic (saturating)
interface apo_inject_queue_if #(
    parameter int K     = 4,
    parameter int N2    = 9,
    parameter int DEPTH = 4
);
    logic                     req_valid;
    logic [K-1:0]             req_dest;
    logic                     req_ready;
    logic [3:0]               link_busy;
    logic [N2-1:0]            out_free;
    logic                     err_dest;
    logic [$clog2(DEPTH):0]   q_level;
    logic [7:0]               inj_count;
    logic [7:0]               stall_count;

    modport master (
        output req_valid, req_dest, link_busy,
        input  req_ready, out_free, err_dest, q_level, inj_count, stall_count
    );

    modport slave (
        input  req_valid, req_dest, link_busy,
        output req_ready, out_free, err_dest, q_level, inj_count, stall_count
    );
endinterface

// File: rtl/apo_inject_queue.sv
// apo_inject_queue
// Injection stage in front of the circulant router's compute-node port.
// Destinations from the node are buffered in a small FIFO and released as
// single-cycle packets {1'b1, zeros, dest}, but only while every neighbour
// link is idle, because in_free wins arbitration inside the router and would
// otherwise displace transit traffic. After each injection a fixed number of
// idle cycles is enforced.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : apo_inject_queue_if.slave (request handshake, link status,
//          packet output, error pulse and statistics)
module apo_inject_queue #(
    parameter int NODE_COUNT = 9,
    parameter int K          = 4,
    parameter int N2         = 9,
    parameter int DEPTH      = 4,
    parameter int GAP        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    apo_inject_queue_if.slave     bus
);

    localparam int PW         = $clog2(DEPTH);
    localparam int CW         = PW + 1;
    localparam int PADW       = N2 - 1 - K;
    localparam int GW         = (GAP < 2) ? 1 : $clog2(GAP);
    localparam int GAP_LOAD_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GW-1:0] GAP_LOAD   = GAP_LOAD_I[GW-1:0];
    localparam logic [K:0]    NODE_LIMIT = NODE_COUNT[K:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   gapCnt_q;

    logic [K-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [CW-1:0]   count_q;

    logic            errDest_q;
    logic [7:0]      injCount_q;
    logic [7:0]      stallCount_q;

    logic            full;
    logic            linksFree;
    logic            accept;
    logic            destOk;
    logic            push;
    logic            pop;
    logic            blocked;
    logic [K-1:0]    head;

    // Handshake and injection decisions. Full blocks acceptance even if the
    // head is popped in the same cycle, so there is no push-through.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        linksFree = (bus.link_busy == 4'b0000);
        accept    = bus.req_valid && !full;
        destOk    = ({1'b0, bus.req_dest} < NODE_LIMIT);
        push      = accept && destOk;
        pop       = (state_q == S_READY) && linksFree;
        blocked   = (state_q == S_READY) && !linksFree;
        head      = mem_q[rdPtr_q];
    end

    // out_free follows link_busy combinationally while a head is waiting.
    assign bus.req_ready   = !full;
    assign bus.out_free    = pop ? {1'b1, {PADW{1'b0}}, head} : '0;
    assign bus.err_dest    = errDest_q;
    assign bus.q_level     = count_q;
    assign bus.inj_count   = injCount_q;
    assign bus.stall_count = stallCount_q;

    // FIFO storage. Pointers wrap naturally because DEPTH is a power of two;
    // storage itself is not cleared on reset, the zeroed pointers discard it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= bus.req_dest;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Injection state machine. IDLE and GAP look only at the registered
    // occupancy, so an entry pushed this cycle is never bypassed to the router.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gapCnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    if (pop) begin
                        if (GAP > 0) begin
                            state_q  <= S_GAP;
                            gapCnt_q <= GAP_LOAD;
                        end else if (count_q > CW'(1)) begin
                            state_q <= S_READY;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gapCnt_q == '0) begin
                        state_q <= (count_q != '0) ? S_READY : S_IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    gapCnt_q <= '0;
                end
            endcase
        end
    end

    // Error pulse and statistics. The injection counter wraps, the stall
    // counter sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            errDest_q    <= 1'b0;
            injCount_q   <= 8'd0;
            stallCount_q <= 8'd0;
        end else begin
            errDest_q <= accept && !destOk;
            if (pop) begin
                injCount_q <= injCount_q + 8'd1;
            end
            if (blocked && (stallCount_q != 8'hFF)) begin
                stallCount_q <= stallCount_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apo_inject_queue.sv
// tb_apo_inject_queue
// Self-checking bench for apo_inject_queue. A monitor keeps a queue of the
// packets the node has handed over and pops it whenever the DUT presents a
// packet on out_free; directed sequences and a randomized phase drive it.
module tb_apo_inject_queue;

    localparam int NODE_COUNT = 9;
    localparam int K          = 4;
    localparam int N2         = 9;
    localparam int DEPTH      = 4;
    localparam int GAP        = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;

    apo_inject_queue_if #(.K(K), .N2(N2), .DEPTH(DEPTH)) bus ();

    apo_inject_queue #(
        .NODE_COUNT (NODE_COUNT),
        .K          (K),
        .N2         (N2),
        .DEPTH      (DEPTH),
        .GAP        (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: packets accepted but not yet injected.
    logic [N2-1:0] expQ [$];
    int            modelInj    = 0;
    bit            errPending  = 1'b0;
    int            cycleNo     = 0;
    int            lastInj     = -100;
    int            starve      = 0;
    bit            modelReady;
    bit            acc;
    logic [N2-1:0] pkt;

    int trDest [$];
    int trExp  [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [K-1:0] d, input logic [3:0] b);
        bus.req_valid = v;
        bus.req_dest  = d;
        bus.link_busy = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 4'b0000);
        tick();
        rst = 1'b0;
    endtask

    // Push trDest back-to-back with free links and compare out_free per cycle.
    task automatic runTrace(input string tag);
        for (int i = 0; i < trExp.size(); i++) begin
            if (i < trDest.size()) applyStimulus(1'b1, K'(trDest[i]), 4'b0000);
            else                   applyStimulus(1'b0, '0, 4'b0000);
            @(negedge clk);
            checkOutput($sformatf("%s_%0d", tag, i), 32'(bus.out_free), 32'(trExp[i]));
            tick();
        end
    endtask

    // Scoreboard monitor: outputs are examined mid-cycle, before the edge
    // that acts on the current inputs.
    always @(negedge clk) begin
        cycleNo++;
        if (rst) begin
            expQ.delete();
            modelInj   = 0;
            errPending = 1'b0;
            lastInj    = -100;
            starve     = 0;
        end else begin
            checkOutput("q_level", 32'(bus.q_level), 32'(expQ.size()));
            modelReady = (expQ.size() < DEPTH);
            checkOutput("req_ready", 32'(bus.req_ready), 32'(modelReady));
            checkOutput("err_dest", 32'(bus.err_dest), 32'(errPending));
            checkOutput("inj_count", 32'(bus.inj_count), 32'(modelInj % 256));
            if (bus.out_free != '0) begin
                checkOutput("inj_links_free", 32'(bus.link_busy), 32'd0);
                checkOutput("inj_spacing_ok", 32'((cycleNo - lastInj) >= GAP + 1), 32'd1);
                checkOutput("inj_latency_ok", 32'(starve <= GAP + 2), 32'd1);
                if (expQ.size() == 0) begin
                    checkOutput("inj_unexpected", 32'(bus.out_free), 32'd0);
                end else begin
                    pkt = expQ.pop_front();
                    checkOutput("out_free", 32'(bus.out_free), 32'(pkt));
                end
                modelInj++;
                lastInj = cycleNo;
                starve  = 0;
            end else if (expQ.size() != 0 && bus.link_busy == 4'b0000) begin
                starve++;
            end else begin
                starve = 0;
            end
            acc = bus.req_valid && modelReady;
            if (acc && int'(bus.req_dest) < NODE_COUNT) begin
                expQ.push_back({1'b1, {(N2-1-K){1'b0}}, bus.req_dest});
            end
            errPending = acc && (int'(bus.req_dest) >= NODE_COUNT);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: actual=expired required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        applyStimulus(1'b0, '0, 4'b0000);
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_free", 32'(bus.out_free), 32'd0);
        checkOutput("rst_err", 32'(bus.err_dest), 32'd0);
        checkOutput("rst_level", 32'(bus.q_level), 32'd0);
        checkOutput("rst_inj", 32'(bus.inj_count), 32'd0);
        checkOutput("rst_stall", 32'(bus.stall_count), 32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
        tick();

        // Single injection, two cycles after the accept edge
        trDest = {5};
        trExp  = {0, 0, 'h105, 0};
        runTrace("single");
        @(negedge clk);
        checkOutput("single_inj", 32'(bus.inj_count), 32'd1);
        checkOutput("single_level", 32'(bus.q_level), 32'd0);
        tick();

        // Back-to-back pushes, one idle cycle after each injection
        doReset();
        trDest = {3, 7, 2};
        trExp  = {0, 0, 'h103, 0, 'h107, 0, 'h102, 0};
        runTrace("burst");
        @(negedge clk);
        checkOutput("burst_inj", 32'(bus.inj_count), 32'd3);
        tick();

        // Blocked by neighbour traffic for six READY cycles
        doReset();
        applyStimulus(1'b1, 4'd4, 4'b0000);
        tick();
        applyStimulus(1'b0, '0, 4'b0100);
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_out_%0d", i), 32'(bus.out_free), 32'd0);
            tick();
        end
        applyStimulus(1'b0, '0, 4'b0000);
        @(negedge clk);
        checkOutput("stall_count", 32'(bus.stall_count), 32'd6);
        checkOutput("stall_release", 32'(bus.out_free), 32'h104);
        tick();
        @(negedge clk);
        checkOutput("stall_after", 32'(bus.out_free), 32'd0);
        checkOutput("stall_inj", 32'(bus.inj_count), 32'd1);
        tick();

        // Fill while links are busy, then drain in order
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, K'(i), 4'b1111);
            tick();
        end
        applyStimulus(1'b1, 4'd6, 4'b1111);
        @(negedge clk);
        checkOutput("full_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("full_level", 32'(bus.q_level), 32'(DEPTH));
        tick();
        @(negedge clk);
        checkOutput("full_hold", 32'(bus.req_ready), 32'd0);
        tick();
        applyStimulus(1'b1, 4'd6, 4'b0000);
        @(negedge clk);
        checkOutput("full_pop_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("full_first", 32'(bus.out_free), 32'h100);
        tick();
        @(negedge clk);
        checkOutput("full_ready_rise", 32'(bus.req_ready), 32'd1);
        tick();
        applyStimulus(1'b0, '0, 4'b0000);
        for (int i = 0; i < 50 && bus.inj_count != 8'd5; i++) tick();
        checkOutput("full_drain", 32'(bus.inj_count), 32'd5);

        // Out-of-range destination is consumed and flagged
        doReset();
        applyStimulus(1'b1, 4'd9, 4'b0000);
        @(negedge clk);
        checkOutput("bad_ready", 32'(bus.req_ready), 32'd1);
        tick();
        applyStimulus(1'b0, '0, 4'b0000);
        @(negedge clk);
        checkOutput("bad_err", 32'(bus.err_dest), 32'd1);
        checkOutput("bad_level", 32'(bus.q_level), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("bad_err_clear", 32'(bus.err_dest), 32'd0);
        checkOutput("bad_no_inject", 32'(bus.out_free), 32'd0);
        tick();
        trDest = {8};
        trExp  = {0, 0, 'h108, 0};
        runTrace("max_dest");

        // Reset while entries are queued and the gap is running
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, K'(i + 2), 4'b0000);
            tick();
        end
        applyStimulus(1'b0, '0, 4'b0000);
        @(negedge clk);
        checkOutput("mid_level", 32'(bus.q_level), 32'd3);
        checkOutput("mid_gap", 32'(bus.out_free), 32'd0);
        tick();
        doReset();
        @(negedge clk);
        checkOutput("mid_rst_out", 32'(bus.out_free), 32'd0);
        checkOutput("mid_rst_level", 32'(bus.q_level), 32'd0);
        checkOutput("mid_rst_inj", 32'(bus.inj_count), 32'd0);
        checkOutput("mid_rst_stall", 32'(bus.stall_count), 32'd0);
        checkOutput("mid_rst_err", 32'(bus.err_dest), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        tick();
        trDest = {1};
        trExp  = {0, 0, 'h101, 0};
        runTrace("after_rst");

        // Stall counter saturation
        doReset();
        applyStimulus(1'b1, 4'd2, 4'b0000);
        tick();
        applyStimulus(1'b0, '0, 4'b0001);
        repeat (300) tick();
        @(negedge clk);
        checkOutput("stall_sat", 32'(bus.stall_count), 32'd255);
        tick();
        applyStimulus(1'b0, '0, 4'b0000);
        repeat (4) tick();

        // Randomized traffic with occasional resets
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 99) < 50,
                              K'($urandom_range(0, 15)),
                              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
                tick();
            end
        end
        applyStimulus(1'b0, '0, 4'b0000);
        for (int i = 0; i < 50 && bus.q_level != '0; i++) tick();
        repeat (3) tick();
        @(negedge clk);
        checkOutput("final_level", 32'(bus.q_level), 32'd0);
        checkOutput("final_model_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apo_inject_queue.md
# apo_inject_queue

Node-side injection stage that sits directly upstream of the circulant router's compute-node port (`in_free`). It buffers destination requests from the compute node in a small FIFO and presents them to the router as single-cycle packets `{1'b1, 0…0, dest}`. It defers injection while any neighbour link carries a packet, because `in_free` has top input priority and would otherwise displace transit traffic. It enforces a minimum gap between injections and keeps injection and error statistics.

## Interface
- `NODE_COUNT`, 9: number of nodes in the circulant; valid destinations are 0..NODE_COUNT-1
- `K`, 4: node-number width
- `N2`, 9: packet width; bit N2-1 is the valid flag
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `GAP`, 1: idle cycles forced after each injection; 0 allowed
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  compute node offers a destination
- `req_dest`  in  K  destination node number
- `req_ready`  out  1  queue can accept; combinational = !full
- `link_busy`  in  4  valid bits (bit N2-1) of the router's in_r1R, in_r2R, in_r1L, in_r2L, in that order
- `out_free`  out  N2  to router `in_free`; combinational
- `err_dest`  out  1  registered one-cycle pulse: an out-of-range destination was dropped
- `q_level`  out  clog2(DEPTH)+1  current FIFO occupancy
- `inj_count`  out  8  packets injected, wraps 255→0
- `stall_count`  out  8  cycles spent in READY blocked by link_busy, saturates at 255

## Operation
- Accept: handshake when `req_valid && req_ready` at an edge.
  - If `req_dest < NODE_COUNT`, push the destination.
  - Otherwise consume the request, do not push, and set `err_dest` for the following cycle.
- Full FIFO: `req_ready`=0 even if a pop happens in the same cycle; no push-through when full.
- Empty FIFO with same-cycle push: the entry becomes visible the next cycle. There is no bypass.
- State machine, registered state:
  - IDLE: FIFO empty; `out_free`=0. Go to READY when `q_level`≠0.
  - READY: head valid. If `link_busy`==0:
    - `out_free = {1'b1, (N2-1-K)'b0, head}`.
    - Pop at the edge and increment `inj_count`.
    - Next state is GAP if GAP>0. Otherwise READY if entries remain, else IDLE.
  - If `link_busy`≠0 in READY: `out_free`=0, no pop, `stall_count`+1 (saturating).
  - GAP: `out_free`=0. A counter loads GAP-1 on entry and decrements each cycle. At 0, go to READY if non-empty, else IDLE. Pushes continue during GAP.
- Destination equal to the local node is legal and injected unchanged; the router asserts its local-delivery flag.
- Width rule: packet payload is zero-extended dest. `K=4`, `N2=9` gives `1_0000_dddd`.

## Timing
- Reset, any cycle including mid-injection:
  - FIFO emptied and pointers zeroed; queued requests are discarded.
  - State IDLE; GAP counter 0.
  - `out_free`=0, `err_dest`=0, `q_level`=0, `inj_count`=0, `stall_count`=0.
  - `req_ready`=1 in the cycle after reset deasserts.
  - Requests presented during the reset cycle are ignored.
- Latency: request accepted at edge t gives `out_free` valid during cycle t+1 (after edge t+1 state update), given links free. The router samples it at edge t+2.
- `out_free` is nonzero for exactly one cycle per packet. It depends combinationally on `link_busy` within READY.
- Throughput: one packet per GAP+1 cycles at best.
- Simultaneous push and pop with non-full FIFO: `q_level` unchanged.
- Pointer wrap at DEPTH is modulo DEPTH; order is strictly FIFO.

## Test plan
- Reset, then single push dest=5 with `link_busy`=0 → `out_free`=9'h105 for exactly one cycle, two cycles after the accept edge; `inj_count`=1; `q_level` returns to 0.
- GAP=1: push 3, 7, 2 back-to-back → `out_free` pulses 9'h103, 9'h107, 9'h102, each followed by one zero cycle; `inj_count`=3.
- Queue one entry and hold `link_busy`=4'b0100 for 6 cycles → `out_free` stays 0 and `stall_count`=6. Release → injection on the next cycle.
- Fill DEPTH=4 while links busy → `req_ready`=0 and a 5th request stays pending. Release links → entries drain in order and `req_ready` rises after the first pop.
- Push dest=9 (NODE_COUNT=9) → accepted with `req_ready`=1, not queued (`q_level`=0), `err_dest`=1 for one cycle, nothing injected. Push dest=8 → injected as 9'h108.
- Assert `rst` while 3 entries are queued and in GAP → next cycle all outputs 0 and queue empty. A new push of dest=1 gives 9'h101.
